decoder3_8_seq: RTL and testbench
=================================

DECODER3_8_SEQ -- requirements
Module: decoder3_8_seq

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the cycles each one-hot output is held; legal range is 1..255.
REQ-002 The block SHALL have parameter GAP, default 0, giving the all-zero cycles inserted between consecutive outputs; legal range is 0..255.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  3-bit code offered.
REQ-006 The block SHALL have port in_data  input  3  binary code 0..7.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-008 The block SHALL have port out_data  output  8  one-hot decode of current code; all-zero when not active.
REQ-009 The block SHALL have port out_active  output  1  high while out_data is non-zero.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse in the last dwell cycle of each code.
REQ-011 The block SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-012 The block SHALL have port fifo_count  output  2  number of queued codes, 0..2.

Function
REQ-013 A code SHALL be accepted on a rising edge where in_valid and in_ready are both high, and written into a 2-entry FIFO.
REQ-014 in_ready SHALL equal (fifo_count != 2); a push is refused when full even if a pop occurs that same cycle.
REQ-015 A pop SHALL only take entries present before the edge; there is no FIFO bypass, and a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-016 The FSM SHALL have the states IDLE, ACTIVE and GAP.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop, register the code, load counter = DWELL-1 and enter ACTIVE.
- Latency: out_data is valid from the edge one cycle after the acceptance edge.
REQ-018 In ACTIVE, out_data SHALL equal 8'b1 << code and the counter SHALL decrement each cycle.
REQ-019 In ACTIVE at counter 0, the FSM SHALL take exactly one of these transitions:
- GAP = 0 and FIFO non-empty: pop and reload DWELL-1, staying in ACTIVE; no zero cycle between codes.
- GAP > 0: load GAP-1 and enter GAP.
- Otherwise: enter IDLE.
REQ-020 In GAP, out_data SHALL be 8'h00; at counter 0 the FSM SHALL pop and enter ACTIVE if the FIFO is non-empty, else enter IDLE.
REQ-021 done SHALL be high exactly in the ACTIVE cycle where counter = 0.
REQ-022 out_data, out_active and done SHALL be registered outputs; out_active SHALL be high only in ACTIVE.
REQ-023 With DWELL = 1, each code SHALL produce exactly one active cycle, with done high in that cycle.

Reset
REQ-024 While rst is high, the block SHALL hold: out_data = 8'h00, out_active = 0, done = 0, busy = 0, fifo_count = 0, in_ready = 1, FSM = IDLE, counter = 0.
REQ-025 Reset asserted mid-ACTIVE or mid-GAP SHALL clear outputs immediately (asynchronously) and discard all queued codes.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Package decoder3_8_pkg SHALL hold:
- the FSM state enum (IDLE, ACTIVE, GAP);
- the code width (3), output width (8) and FIFO depth (2) constants.
REQ-028 The 2-entry FIFO SHALL be a sub-module named code_fifo2, with push, pop, din, dout, count, full and empty ports.
REQ-029 The FSM, counter and decode register SHALL reside in decoder3_8_seq.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- DWELL = 4, GAP = 0: accept 3'd5 -> out_data = 8'h20 for 4 cycles starting 1 cycle after acceptance, done on the 4th cycle, then 8'h00 and busy = 0.
- DWELL = 4, GAP = 0: accept 3'd0 then 3'd7 back-to-back -> 8'h01 x4 then 8'h80 x4 with no zero cycle; done pulses twice.
- DWELL = 4: push 3 codes during ACTIVE -> fifo_count reaches 2, in_ready = 0 while full, the third code is accepted only after a pop, and all codes appear in order.
- DWELL = 2, GAP = 2: accept 3'd1, 3'd2 -> 8'h02 x2, 8'h00 x2, 8'h04 x2.
- Reset asserted in the 2nd ACTIVE cycle with 2 queued codes -> out_data = 8'h00 immediately, fifo_count = 0, and no further output after release.
- Sweep codes 0..7, DWELL = 1 -> out_data = 8'h01, 02, 04 ... 80, each exactly one cycle.

Source files
------------

// File: rtl/decoder3_8_pkg.sv
// ============================================================================
// decoder3_8_pkg : shared types and constants for the sequenced 3-to-8 decoder
// Revision 1.0
// ============================================================================
`default_nettype none

package decoder3_8_pkg;

    localparam int unsigned c_code_w     = 3;
    localparam int unsigned c_out_w      = 8;
    localparam int unsigned c_fifo_depth = 2;
    localparam int unsigned c_cnt_w      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    function automatic logic [c_out_w-1:0] onehot(input logic [c_code_w-1:0] code);
        logic [c_out_w-1:0] one;
        one = {{(c_out_w-1){1'b0}}, 1'b1};
        return one << code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder3_8_seq_fifo.sv
// ============================================================================
// code_fifo2 : two-entry code FIFO; full refuses pushes, empty refuses pops
// Revision 1.0
// ============================================================================
`default_nettype none

module code_fifo2
    import decoder3_8_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [c_code_w-1:0] din,
    output logic [c_code_w-1:0] dout,
    output logic [1:0]          count,
    output logic                full,
    output logic                empty
);

    logic [c_code_w-1:0] mem_q [c_fifo_depth];
    logic [c_code_w-1:0] mem_d [c_fifo_depth];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q,  count_d;
    logic                do_push, do_pop;

    assign full  = (count_q == 2'(c_fifo_depth));
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decoder3_8_seq.sv
// ============================================================================
// decoder3_8_seq : queues 3-bit codes and plays each out as a one-hot pattern
//                  held for DWELL cycles, optionally separated by GAP zeros
// Revision 1.0
// ============================================================================
`default_nettype none

module decoder3_8_seq
    import decoder3_8_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [c_code_w-1:0] in_data,
    output logic                in_ready,
    output logic [c_out_w-1:0]  out_data,
    output logic                out_active,
    output logic                done,
    output logic                busy,
    output logic [1:0]          fifo_count
);

    localparam logic [c_cnt_w-1:0] c_dwell_ld = c_cnt_w'(DWELL - 1);
    localparam logic [c_cnt_w-1:0] c_gap_ld   = (GAP > 0) ? c_cnt_w'(GAP - 1) : '0;

    state_e              state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
    logic [c_code_w-1:0] code_q,  code_d;
    logic [c_out_w-1:0]  out_data_q, out_data_d;
    logic                out_active_q, out_active_d;
    logic                done_q, done_d;

    logic                fifo_pop;
    logic [c_code_w-1:0] fifo_dout;
    logic                fifo_full, fifo_empty;

    code_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready   = !fifo_full;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);
    assign out_data   = out_data_q;
    assign out_active = out_active_q;
    assign done       = done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    code_d   = fifo_dout;
                    cnt_d    = c_dwell_ld;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP == 0 && !fifo_empty) begin
                    // Back-to-back codes with no zero cycle in between
                    fifo_pop = 1'b1;
                    code_d   = fifo_dout;
                    cnt_d    = c_dwell_ld;
                end else if (GAP > 0) begin
                    cnt_d   = c_gap_ld;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    code_d   = fifo_dout;
                    cnt_d    = c_dwell_ld;
                    state_d  = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        out_active_d = (state_d == ST_ACTIVE);
        out_data_d   = out_active_d ? onehot(code_d) : '0;
        done_d       = out_active_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            out_data_q   <= '0;
            out_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            out_data_q   <= out_data_d;
            out_active_q <= out_active_d;
            done_q       <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder3_8_seq.sv
// ============================================================================
// tb_decoder3_8_seq : directed self-checking bench, three parameterisations
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_decoder3_8_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // a: DWELL=4 GAP=0, b: DWELL=2 GAP=2, c: DWELL=1 GAP=0
    logic       v_a, v_b, v_c;
    logic [2:0] d_a, d_b, d_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] o_a, o_b, o_c;
    logic       act_a, act_b, act_c;
    logic       done_a, done_b, done_c;
    logic       busy_a, busy_b, busy_c;
    logic [1:0] cnt_a, cnt_b, cnt_c;

    decoder3_8_seq #(.DWELL(4), .GAP(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(v_a), .in_data(d_a), .in_ready(rdy_a),
        .out_data(o_a), .out_active(act_a), .done(done_a), .busy(busy_a), .fifo_count(cnt_a));
    decoder3_8_seq #(.DWELL(2), .GAP(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(v_b), .in_data(d_b), .in_ready(rdy_b),
        .out_data(o_b), .out_active(act_b), .done(done_b), .busy(busy_b), .fifo_count(cnt_b));
    decoder3_8_seq #(.DWELL(1), .GAP(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(v_c), .in_data(d_c), .in_ready(rdy_c),
        .out_data(o_c), .out_active(act_c), .done(done_c), .busy(busy_c), .fifo_count(cnt_c));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Record the code shown in every done cycle of instance a
    logic [7:0] log_a [16];
    int         log_n = 0;
    always @(negedge clk) begin
        if (done_a && log_n < 16) begin
            log_a[log_n] <= o_a;
            log_n        <= log_n + 1;
        end
    end

    initial begin
        logic [7:0] exp_o;
        logic       exp_d;
        int         base;
        int         waited;
        logic       was_ready;
        logic [7:0] exp_seq [4];

        rst = 1'b1;
        v_a = 0; v_b = 0; v_c = 0;
        d_a = '0; d_b = '0; d_c = '0;
        tick; tick;

        check_eq("rst_out_data", o_a, 8'h00);
        check_eq("rst_active",   act_a, 0);
        check_eq("rst_done",     done_a, 0);
        check_eq("rst_busy",     busy_a, 0);
        check_eq("rst_count",    cnt_a, 0);
        check_eq("rst_ready",    rdy_a, 1);
        rst = 1'b0;

        // S1: single code 5, first edge after reset release
        v_a = 1; d_a = 3'd5;
        tick;
        v_a = 0;
        check_eq("s1_acc_out",   o_a, 8'h00);
        check_eq("s1_acc_count", cnt_a, 1);
        for (int k = 1; k <= 5; k++) begin
            tick;
            exp_o = (k <= 4) ? 8'h20 : 8'h00;
            check_eq($sformatf("s1_out_k%0d", k),  o_a, exp_o);
            check_eq($sformatf("s1_done_k%0d", k), done_a, (k == 4));
        end
        check_eq("s1_busy_end", busy_a, 0);

        // S2: 0 then 7 back-to-back, no zero cycle between
        v_a = 1; d_a = 3'd0;
        tick;
        d_a = 3'd7;
        for (int k = 1; k <= 9; k++) begin
            tick;
            v_a = 0;
            exp_o = (k <= 4) ? 8'h01 : (k <= 8) ? 8'h80 : 8'h00;
            exp_d = (k == 4) || (k == 8);
            check_eq($sformatf("s2_out_k%0d", k),  o_a, exp_o);
            check_eq($sformatf("s2_done_k%0d", k), done_a, exp_d);
        end
        check_eq("s2_busy_end", busy_a, 0);

        // S3: fill the FIFO while active; the third push must wait for a pop
        base = log_n;
        v_a = 1; d_a = 3'd3;
        tick;
        v_a = 0;
        tick;
        v_a = 1; d_a = 3'd1;
        tick;
        d_a = 3'd6;
        tick;
        check_eq("s3_count_full", cnt_a, 2);
        check_eq("s3_ready_full", rdy_a, 0);
        d_a = 3'd2;
        waited = -1;
        for (int i = 0; i < 10; i++) begin
            was_ready = rdy_a;
            tick;
            if (was_ready) begin
                waited = i;
                break;
            end
        end
        v_a = 0;
        check_eq("s3_wait_cycles", waited, 2);
        check_eq("s3_count_after", cnt_a, 2);
        for (int i = 0; i < 40 && busy_a; i++) tick;
        check_eq("s3_idle", busy_a, 0);
        tick;
        exp_seq[0] = 8'h08; exp_seq[1] = 8'h02; exp_seq[2] = 8'h40; exp_seq[3] = 8'h04;
        check_eq("s3_n_codes", log_n - base, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("s3_order_%0d", i), log_a[base + i], exp_seq[i]);

        // S4: DWELL=2 GAP=2, codes 1 and 2
        v_b = 1; d_b = 3'd1;
        tick;
        d_b = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            tick;
            v_b = 0;
            case (k)
                1, 2:    exp_o = 8'h02;
                5, 6:    exp_o = 8'h04;
                default: exp_o = 8'h00;
            endcase
            check_eq($sformatf("s4_out_k%0d", k),  o_b, exp_o);
            check_eq($sformatf("s4_act_k%0d", k),  act_b, (exp_o != 8'h00));
            check_eq($sformatf("s4_done_k%0d", k), done_b, (k == 2) || (k == 6));
        end
        tick; tick;
        check_eq("s4_busy_end", busy_b, 0);

        // S5: reset in 2nd active cycle with two codes queued
        v_a = 1; d_a = 3'd4;
        tick;
        d_a = 3'd5;
        tick;
        d_a = 3'd6;
        tick;
        v_a = 0;
        check_eq("s5_pre_out",   o_a, 8'h10);
        check_eq("s5_pre_count", cnt_a, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("s5_async_out",   o_a, 8'h00);
        check_eq("s5_async_act",   act_a, 0);
        check_eq("s5_async_count", cnt_a, 0);
        check_eq("s5_async_busy",  busy_a, 0);
        check_eq("s5_async_ready", rdy_a, 1);
        tick;
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            check_eq($sformatf("s5_post_out_k%0d", k), o_a, 8'h00);
            check_eq($sformatf("s5_post_busy_k%0d", k), busy_a, 0);
        end

        // S6: DWELL=1 sweep of all eight codes, one cycle each
        v_c = 1;
        for (int i = 0; i < 8; i++) begin
            d_c = 3'(i);
            tick;
            if (i > 0) begin
                exp_o = 8'h01 << (i - 1);
                check_eq($sformatf("s6_out_%0d", i - 1),  o_c, exp_o);
                check_eq($sformatf("s6_done_%0d", i - 1), done_c, 1);
            end
        end
        v_c = 0;
        tick;
        check_eq("s6_out_7",  o_c, 8'h80);
        check_eq("s6_done_7", done_c, 1);
        tick;
        check_eq("s6_out_end",  o_c, 8'h00);
        check_eq("s6_done_end", done_c, 0);
        check_eq("s6_busy_end", busy_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
